// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PCs, reads one word at a time from
// instruction memory and buffers {pc, instr, fault} entries for decode.
module instr_fetch_unit #(
  parameter int ARCHITECTURE = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ARCHITECTURE-1:0] pc_i,
  input  logic                    pc_valid_i,
  output logic                    pc_ready_o,
  output logic                    imem_req_o,
  output logic [ARCHITECTURE-1:0] imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [ARCHITECTURE-1:0] imem_data_i,
  input  logic                    flush_i,
  output logic                    instr_valid_o,
  output logic [ARCHITECTURE-1:0] instr_o,
  output logic [ARCHITECTURE-1:0] instr_pc_o,
  output logic                    fault_o,
  input  logic                    instr_ready_i
);

  localparam int AW = ARCHITECTURE;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] instr;
    logic          fault;
  } entry_t;

  state_t        r_state;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  entry_t        r_mem [FIFO_DEPTH];

  logic   w_idle;
  logic   w_accept;
  logic   w_misal;
  logic   w_push_mis;
  logic   w_push_ack;
  logic   w_push;
  logic   w_pop;
  entry_t w_wdata;
  entry_t w_head;

  assign w_idle     = (r_state == S_IDLE);
  assign pc_ready_o = w_idle && (r_count < DEPTH_C) && !flush_i;
  assign w_accept   = pc_valid_i && pc_ready_o;
  assign w_misal    = (pc_i[1:0] != 2'b00);
  assign w_push_mis = w_accept && w_misal;
  assign w_push_ack = (r_state == S_WAIT) && imem_ack_i;
  assign w_push     = (w_push_mis || w_push_ack) && !flush_i;
  assign w_pop      = instr_valid_o && instr_ready_i;

  always_comb begin
    w_wdata = '0;
    if (w_push_mis) begin
      w_wdata.pc    = pc_i;
      w_wdata.fault = 1'b1;
    end else begin
      w_wdata.pc    = r_addr;
      w_wdata.instr = imem_data_i;
    end
  end

  // Slot for a fetch is reserved at acceptance, so this write never overflows.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && !w_misal) begin
            r_addr  <= pc_i;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end else if (flush_i) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (imem_ack_i) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = (r_count != '0);
  assign w_head        = instr_valid_o ? r_mem[r_rd_ptr] : '0;
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;
  assign fault_o       = w_head.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic,
// all checked each cycle against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_valid;
  logic          pc_ready;
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [AW-1:0] data;
  logic          flush;
  logic          ivalid;
  logic [AW-1:0] instr;
  logic [AW-1:0] ipc;
  logic          fault;
  logic          iready;

  instr_fetch_unit #(.ARCHITECTURE(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_i         (pc),
    .pc_valid_i   (pc_valid),
    .pc_ready_o   (pc_ready),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_data_i  (data),
    .flush_i      (flush),
    .instr_valid_o(ivalid),
    .instr_o      (instr),
    .instr_pc_o   (ipc),
    .fault_o      (fault),
    .instr_ready_i(iready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] ins;
    logic          flt;
  } ent_t;

  ent_t          m_q[$];
  bit            m_busy;
  bit            m_drop;
  logic [AW-1:0] m_addr;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]} + 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ackm: 0 = no ack, 1 = ack, 2 = ack whenever a request is outstanding
  task automatic step(input bit v, input logic [AW-1:0] p, input int ackm,
                      input bit fl, input bit rdy, input bit rs);
    logic [AW-1:0] e_ins;
    logic [AW-1:0] e_pc;
    logic          e_flt;
    bit            e_valid;
    bit            e_ready;
    bit            pop;
    bit            acc;
    rst      = rs;
    pc_valid = v;
    pc       = p;
    flush    = fl;
    iready   = rdy;
    ack      = (ackm == 1) || (ackm == 2 && m_busy);
    data     = m_busy ? mem_word(m_addr) : $urandom;
    @(negedge clk);
    e_valid = (m_q.size() != 0);
    e_ready = !m_busy && (m_q.size() < DEPTH) && !fl;
    e_ins   = e_valid ? m_q[0].ins : '0;
    e_pc    = e_valid ? m_q[0].pc  : '0;
    e_flt   = e_valid ? m_q[0].flt : 1'b0;
    chk("pc_ready", AW'(pc_ready), AW'(e_ready));
    chk("imem_req", AW'(req), AW'(m_busy));
    chk("imem_addr", addr, m_addr);
    chk("instr_valid", AW'(ivalid), AW'(e_valid));
    chk("instr", instr, e_ins);
    chk("instr_pc", ipc, e_pc);
    chk("fault", AW'(fault), AW'(e_flt));
    pop = e_valid && rdy;
    acc = v && e_ready;
    if (rs) begin
      m_q.delete();
      m_busy = 0;
      m_drop = 0;
      m_addr = '0;
    end else if (fl) begin
      m_q.delete();
      if (m_busy) begin
        if (ack) m_busy = 0;
        else     m_drop = 1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (p[1:0] != 2'b00) begin
          m_q.push_back('{pc: p, ins: '0, flt: 1'b1});
        end else begin
          m_busy = 1;
          m_drop = 0;
          m_addr = p;
        end
      end else if (m_busy && ack) begin
        m_busy = 0;
        if (!m_drop) m_q.push_back('{pc: m_addr, ins: data, flt: 1'b0});
        m_drop = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_busy = 0;
    m_drop = 0;
    m_addr = '0;
    rst = 1; pc_valid = 0; pc = '0; ack = 0;
    data = '0; flush = 0; iready = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);

    // back-to-back aligned fetches, ack one cycle after acceptance
    for (int i = 0; i < 3; i++) begin
      step(1, AW'(4 * i), 0, 0, 1, 0);
      step(0, 0, 1, 0, 1, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // fill the buffer with decode stalled, then drain across the wrap
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h100 + AW'(4 * i), 0, 0, 0, 0);
      step(0, 0, 2, 0, 0, 0);
    end
    step(1, 32'h110, 0, 0, 0, 0);
    step(1, 32'h110, 0, 0, 1, 0);
    step(1, 32'h110, 0, 0, 1, 0);
    step(0, 0, 2, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 2, 0, 1, 0);

    // misaligned PC goes straight to the buffer
    step(1, 32'h6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // flush while waiting, late ack discarded
    step(1, 32'h10, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 32'h14, 0, 0, 1, 0);
    step(1, 32'h14, 1, 0, 1, 0);
    step(1, 32'h20, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // two buffered, one in flight, flush with pop and ack together
    step(1, 32'h30, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 32'h35, 0, 0, 0, 0);
    step(1, 32'h38, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);

    // reset mid-fetch, late ack ignored
    step(1, 32'h40, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] rp;
      rp = {$urandom} & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      step(bit'($urandom_range(0, 1)), rp,
           ($urandom_range(0, 2) != 0) ? 2 : 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
